// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the I2C SCL generator
package i2c_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LOW     = 2'd1,
      ST_STRETCH = 2'd2,
      ST_HIGH    = 2'd3
   } scl_state_e;

   localparam logic [1:0] MODE_SM = 2'd0;
   localparam logic [1:0] MODE_FM = 2'd1;
   localparam logic [1:0] MODE_FP = 2'd2;

   // Phase lengths in 50 MHz cycles
   localparam int DEF_LOW_SM  = 250;
   localparam int DEF_HIGH_SM = 250;
   localparam int DEF_LOW_FM  = 75;
   localparam int DEF_HIGH_FM = 50;
   localparam int DEF_LOW_FP  = 30;
   localparam int DEF_HIGH_FP = 20;

   function automatic int max_of6(input int a, input int b, input int c,
                                  input int d, input int e, input int f);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      if (e > m) m = e;
      if (f > m) m = f;
      return m;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for a level that idles high
module sync_2ff (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/i2c_scl_gen.sv
// rtl/i2c_scl_gen.sv - open-drain SCL generator with SM/FM/FM+ rates and phase strobes
// Define I2C_SCL_STRETCH_EN to honour slave clock stretching via the scl_in_i pad level.
module i2c_scl_gen
   import i2c_pkg::*;
#(
   parameter int LOW_SM  = DEF_LOW_SM,
   parameter int HIGH_SM = DEF_HIGH_SM,
   parameter int LOW_FM  = DEF_LOW_FM,
   parameter int HIGH_FM = DEF_HIGH_FM,
   parameter int LOW_FP  = DEF_LOW_FP,
   parameter int HIGH_FP = DEF_HIGH_FP
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       en_i,
   input  logic [1:0] freq_mode_i,
   input  logic       scl_in_i,
   output logic       scl_oe_o,
   output logic       scl_fall_o,
   output logic       scl_rise_o,
   output logic       low_mid_o,
   output logic       high_mid_o,
   output logic       busy_o,
   output logic       stretching_o
);

   localparam int MAX_LEN = max_of6(LOW_SM, HIGH_SM, LOW_FM, HIGH_FM, LOW_FP, HIGH_FP);
   localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   typedef logic [CNT_W-1:0] cnt_t;

   localparam cnt_t L_SM_LAST = cnt_t'(LOW_SM - 1);
   localparam cnt_t L_FM_LAST = cnt_t'(LOW_FM - 1);
   localparam cnt_t L_FP_LAST = cnt_t'(LOW_FP - 1);
   localparam cnt_t H_SM_LAST = cnt_t'(HIGH_SM - 1);
   localparam cnt_t H_FM_LAST = cnt_t'(HIGH_FM - 1);
   localparam cnt_t H_FP_LAST = cnt_t'(HIGH_FP - 1);
   localparam cnt_t L_SM_MID  = cnt_t'(LOW_SM / 2);
   localparam cnt_t L_FM_MID  = cnt_t'(LOW_FM / 2);
   localparam cnt_t L_FP_MID  = cnt_t'(LOW_FP / 2);
   localparam cnt_t H_SM_MID  = cnt_t'(HIGH_SM / 2);
   localparam cnt_t H_FM_MID  = cnt_t'(HIGH_FM / 2);
   localparam cnt_t H_FP_MID  = cnt_t'(HIGH_FP / 2);

   // Mode 3 and anything unknown fall back to standard mode
   function automatic cnt_t low_last_f(input logic [1:0] m);
      case (m)
         MODE_FM: return L_FM_LAST;
         MODE_FP: return L_FP_LAST;
         default: return L_SM_LAST;
      endcase
   endfunction

   function automatic cnt_t high_last_f(input logic [1:0] m);
      case (m)
         MODE_FM: return H_FM_LAST;
         MODE_FP: return H_FP_LAST;
         default: return H_SM_LAST;
      endcase
   endfunction

   function automatic cnt_t low_mid_f(input logic [1:0] m);
      case (m)
         MODE_FM: return L_FM_MID;
         MODE_FP: return L_FP_MID;
         default: return L_SM_MID;
      endcase
   endfunction

   function automatic cnt_t high_mid_f(input logic [1:0] m);
      case (m)
         MODE_FM: return H_FM_MID;
         MODE_FP: return H_FP_MID;
         default: return H_SM_MID;
      endcase
   endfunction

   scl_state_e state_q, state_d;
   cnt_t       cnt_q, cnt_d;
   logic [1:0] cur_mode_q, cur_mode_d;
   logic       scl_oe_q, scl_oe_d;
   logic       scl_fall_q, scl_fall_d;
   logic       scl_rise_q, scl_rise_d;
   logic       low_mid_q, low_mid_d;
   logic       high_mid_q, high_mid_d;
   logic       busy_q, busy_d;
   logic       stretching_q, stretching_d;

`ifdef I2C_SCL_STRETCH_EN
   logic scl_sync;

   sync_2ff u_scl_sync (
      .clk_i (clk_i),
      .rst_i (reset_i),
      .d_i   (scl_in_i),
      .q_o   (scl_sync)
   );
`else
   logic unused_scl_in;
   assign unused_scl_in = scl_in_i;
`endif

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         cur_mode_q   <= MODE_SM;
         scl_oe_q     <= 1'b0;
         scl_fall_q   <= 1'b0;
         scl_rise_q   <= 1'b0;
         low_mid_q    <= 1'b0;
         high_mid_q   <= 1'b0;
         busy_q       <= 1'b0;
         stretching_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         cur_mode_q   <= cur_mode_d;
         scl_oe_q     <= scl_oe_d;
         scl_fall_q   <= scl_fall_d;
         scl_rise_q   <= scl_rise_d;
         low_mid_q    <= low_mid_d;
         high_mid_q   <= high_mid_d;
         busy_q       <= busy_d;
         stretching_q <= stretching_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = '0;
      cur_mode_d = cur_mode_q;
      case (state_q)
         ST_IDLE: begin
            if (en_i) state_d = ST_LOW;
         end
         ST_LOW: begin
            if (cnt_q == low_last_f(cur_mode_q)) begin
`ifdef I2C_SCL_STRETCH_EN
               state_d = ST_STRETCH;
`else
               state_d = ST_HIGH;
`endif
            end
         end
         ST_STRETCH: begin
`ifdef I2C_SCL_STRETCH_EN
            if (scl_sync) state_d = ST_HIGH;
`else
            state_d = ST_HIGH;
`endif
         end
         ST_HIGH: begin
            if (cnt_q == high_last_f(cur_mode_q)) state_d = en_i ? ST_LOW : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // The rate is frozen for the whole period at the moment SCL is pulled low
      if (state_d == ST_LOW && state_q != ST_LOW) cur_mode_d = freq_mode_i;

      if (state_d == state_q && (state_q == ST_LOW || state_q == ST_HIGH)) cnt_d = cnt_q + 1'b1;
   end

   // Outputs are decoded from the next state so the registered copies line up with state_q
   always_comb begin
      scl_oe_d   = (state_d == ST_LOW);
      scl_fall_d = (state_d == ST_LOW) && (state_q != ST_LOW);
      scl_rise_d = (state_d == ST_HIGH) && (state_q != ST_HIGH);
      low_mid_d  = (state_d == ST_LOW) && (cnt_d == low_mid_f(cur_mode_d));
      high_mid_d = (state_d == ST_HIGH) && (cnt_d == high_mid_f(cur_mode_d));
      busy_d     = (state_d != ST_IDLE);
`ifdef I2C_SCL_STRETCH_EN
      stretching_d = (state_d == ST_STRETCH);
`else
      stretching_d = 1'b0;
`endif
   end

   assign scl_oe_o     = scl_oe_q;
   assign scl_fall_o   = scl_fall_q;
   assign scl_rise_o   = scl_rise_q;
   assign low_mid_o    = low_mid_q;
   assign high_mid_o   = high_mid_q;
   assign busy_o       = busy_q;
   assign stretching_o = stretching_q;

endmodule
